// File: rtl/shared_adder_scheduler.sv
// Round-robin scheduler sharing a single unsigned adder among NUM_REQ requesters.
// One operation per IDLE -> CALC -> RESP pass; the result returns with its owner's ID.
module shared_adder_scheduler #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8,
    parameter int NUM_REQ = 4,
    localparam int WIDTH_OUT = 1 + ((WIDTH_A > WIDTH_B) ? WIDTH_A : WIDTH_B),
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH_A-1:0] a_in,
    input  logic [NUM_REQ*WIDTH_B-1:0] b_in,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic [WIDTH_OUT-1:0]       result,
    output logic [ID_W-1:0]            result_id,
    output logic                       result_valid,
    input  logic                       result_ready
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t              state;
    state_t              state_nx;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     ptr_nx;
    logic [ID_W-1:0]     win;
    logic [ID_W-1:0]     cand;
    logic [ID_W:0]       sum_w;
    logic                found;
    logic [ID_W-1:0]     id_reg;
    logic [WIDTH_A-1:0]  a_reg;
    logic [WIDTH_B-1:0]  b_reg;

    // Search upward from ptr, wrapping at NUM_REQ-1 (NUM_REQ need not be a power of two).
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum_w = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_w = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum_w >= (ID_W+1)'(NUM_REQ)) begin
                sum_w = sum_w - (ID_W+1)'(NUM_REQ);
            end
            cand = sum_w[ID_W-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign ptr_nx = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (found) state_nx = CALC;
            CALC:    state_nx = RESP;
            RESP:    if (result_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            gnt          <= '0;
            ptr          <= '0;
            id_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            result       <= '0;
            result_id    <= '0;
            result_valid <= 1'b0;
        end else begin
            gnt <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        a_reg  <= a_in[win*WIDTH_A +: WIDTH_A];
                        b_reg  <= b_in[win*WIDTH_B +: WIDTH_B];
                        id_reg <= win;
                        ptr    <= ptr_nx;
                        gnt    <= NUM_REQ'(1) << win;
                    end
                end
                CALC: begin
                    // Each operand is zero-extended from its own width, so the carry survives.
                    result       <= WIDTH_OUT'(a_reg) + WIDTH_OUT'(b_reg);
                    result_id    <= id_reg;
                    result_valid <= 1'b1;
                end
                RESP: begin
                    if (result_ready) result_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
